// File: rtl/load_ext_ctrl_if.sv
// Bus bundle for load_ext_ctrl: load request, memory read handshake and result.
//   master : the load controller side (drives ld_ready, mem_req/addr, res_*)
//   slave  : the pipeline/memory side (drives ld_valid/addr/type, mem_ack/rdata, res_ready)
interface load_ext_ctrl_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_type;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_err;

    modport master (
        input  ld_valid, ld_addr, ld_type, mem_ack, mem_rdata, res_ready,
        output ld_ready, mem_req, mem_addr, res_valid, res_data, res_err
    );

    modport slave (
        output ld_valid, ld_addr, ld_type, mem_ack, mem_rdata, res_ready,
        input  ld_ready, mem_req, mem_addr, res_valid, res_data, res_err
    );
endinterface

// File: rtl/load_ext_ctrl.sv
// Sub-word load sequencer for the MEM stage. Accepts one load, fetches the aligned
// word over a req/ack handshake, extracts and extends the byte/halfword, and holds
// the result until consumed. Misaligned, illegal-type and timed-out accesses are
// reported through res_err with res_data=0.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : load_ext_ctrl_if.master (ld_*, mem_*, res_* signals)
// Parameter:
//   TIMEOUT : max cycles mem_req stays high without mem_ack (1..65535)
//
// state | meaning
// IDLE  | ready for a request (ld_ready=1)
// REQ   | memory read outstanding (mem_req=1), timer running
// DONE  | result held (res_valid=1) until res_ready
module load_ext_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    load_ext_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [2:0] T_LW  = 3'd0;
    localparam logic [2:0] T_LH  = 3'd1;
    localparam logic [2:0] T_LHU = 3'd2;
    localparam logic [2:0] T_LB  = 3'd3;
    localparam logic [2:0] T_LBU = 3'd4;

    localparam logic [1:0] E_OK    = 2'd0;
    localparam logic [1:0] E_ALIGN = 2'd1;
    localparam logic [1:0] E_TMO   = 2'd2;
    localparam logic [1:0] E_TYPE  = 2'd3;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_nxt;
    logic [1:0]  lane_q, lane_nxt;
    logic [2:0]  type_q, type_nxt;
    logic [15:0] timer_q, timer_nxt;
    logic [31:0] mem_addr_q, mem_addr_nxt;
    logic [31:0] data_q, data_nxt;
    logic [1:0]  err_q, err_nxt;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Lane selection and extension work from the captured request, so the result
    // only depends on mem_rdata in the cycle the ack is taken.
    always_comb begin
        byte_sel = 8'h00;
        case (lane_q)
            2'd0: byte_sel = bus.mem_rdata[7:0];
            2'd1: byte_sel = bus.mem_rdata[15:8];
            2'd2: byte_sel = bus.mem_rdata[23:16];
            2'd3: byte_sel = bus.mem_rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        ext_data = 32'h0;
        case (type_q)
            T_LW:    ext_data = bus.mem_rdata;
            T_LH:    ext_data = {{16{half_sel[15]}}, half_sel};
            T_LHU:   ext_data = {16'h0, half_sel};
            T_LB:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            T_LBU:   ext_data = {24'h0, byte_sel};
            default: ext_data = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt    = state_q;
        lane_nxt     = lane_q;
        type_nxt     = type_q;
        timer_nxt    = timer_q;
        mem_addr_nxt = mem_addr_q;
        data_nxt     = data_q;
        err_nxt      = err_q;

        case (state_q)
            IDLE: begin
                if (bus.ld_valid) begin
                    lane_nxt = bus.ld_addr[1:0];
                    type_nxt = bus.ld_type;
                    // Type is checked before alignment so an illegal type with a
                    // bad address still reports as illegal.
                    if (bus.ld_type > T_LBU) begin
                        state_nxt = DONE;
                        err_nxt   = E_TYPE;
                        data_nxt  = 32'h0;
                    end else if ((bus.ld_type == T_LW && bus.ld_addr[1:0] != 2'b00) ||
                                 ((bus.ld_type == T_LH || bus.ld_type == T_LHU) &&
                                  bus.ld_addr[0])) begin
                        state_nxt = DONE;
                        err_nxt   = E_ALIGN;
                        data_nxt  = 32'h0;
                    end else begin
                        state_nxt    = REQ;
                        timer_nxt    = 16'h0;
                        mem_addr_nxt = {bus.ld_addr[31:2], 2'b00};
                    end
                end
            end
            REQ: begin
                // An ack arriving in the expiry cycle still completes the load.
                if (bus.mem_ack) begin
                    state_nxt = DONE;
                    data_nxt  = ext_data;
                    err_nxt   = E_OK;
                end else if (timer_q == TMO_LAST) begin
                    state_nxt = DONE;
                    data_nxt  = 32'h0;
                    err_nxt   = E_TMO;
                end else begin
                    timer_nxt = timer_q + 16'd1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lane_q     <= 2'b00;
            type_q     <= 3'b000;
            timer_q    <= 16'h0;
            mem_addr_q <= 32'h0;
            data_q     <= 32'h0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_nxt;
            lane_q     <= lane_nxt;
            type_q     <= type_nxt;
            timer_q    <= timer_nxt;
            mem_addr_q <= mem_addr_nxt;
            data_q     <= data_nxt;
            err_q      <= err_nxt;
        end
    end

    // Handshake outputs are pure state decodes, so reset drops them at once.
    assign bus.ld_ready  = (state_q == IDLE);
    assign bus.mem_req   = (state_q == REQ);
    assign bus.res_valid = (state_q == DONE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.res_data  = data_q;
    assign bus.res_err   = err_q;
endmodule

// File: tb/tb_load_ext_ctrl.sv
module tb_load_ext_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    load_ext_ctrl_if bus ();

    load_ext_ctrl #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] addr, input logic [2:0] typ);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_type  = typ;
        step();
        bus.ld_valid = 1'b0;
    endtask

    // Ack in the current REQ cycle, then check the completed result.
    task automatic ack_and_check(input string tag, input logic [31:0] rdata,
                                 input logic [31:0] exp);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ack   = 1'b0;
        chk1({tag, "_valid"}, bus.res_valid, 1'b1);
        chk32({tag, "_data"}, bus.res_data, exp);
        chk2({tag, "_err"}, bus.res_err, 2'd0);
    endtask

    task automatic consume(input string tag);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk1({tag, "_valid_low"}, bus.res_valid, 1'b0);
        chk1({tag, "_ready"}, bus.ld_ready, 1'b1);
    endtask

    initial begin
        int n_req;
        logic done_seen;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = 32'h0;
        bus.ld_type   = 3'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.res_ready = 1'b0;

        #3;
        chk1("rst_ld_ready", bus.ld_ready, 1'b1);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk32("rst_mem_addr", bus.mem_addr, 32'h0);
        chk1("rst_res_valid", bus.res_valid, 1'b0);
        chk32("rst_res_data", bus.res_data, 32'h0);
        chk2("rst_res_err", bus.res_err, 2'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: lb at 0x1003, ack on the second REQ cycle
        issue(32'h0000_1003, 3'd3);
        chk1("t1_mem_req", bus.mem_req, 1'b1);
        chk32("t1_mem_addr", bus.mem_addr, 32'h0000_1000);
        chk1("t1_ld_ready", bus.ld_ready, 1'b0);
        step();
        chk1("t1_req_hold", bus.mem_req, 1'b1);
        ack_and_check("t1", 32'h80FF_1234, 32'hFFFF_FF80);
        chk1("t1_req_low", bus.mem_req, 1'b0);
        consume("t1");

        // other byte lanes
        issue(32'h0000_1001, 3'd3);
        ack_and_check("lb_lane1", 32'h80FF_1234, 32'h0000_0012);
        consume("lb_lane1");
        issue(32'h0000_1002, 3'd4);
        ack_and_check("lbu_lane2", 32'h80FF_1234, 32'h0000_00FF);
        consume("lbu_lane2");

        // 2: halfwords
        issue(32'h0000_2002, 3'd2);
        ack_and_check("t2_lhu", 32'h8001_7FFF, 32'h0000_8001);
        consume("t2_lhu");
        issue(32'h0000_2002, 3'd1);
        ack_and_check("t2_lh", 32'h8001_7FFF, 32'hFFFF_8001);
        consume("t2_lh");
        issue(32'h0000_2000, 3'd1);
        ack_and_check("lh_low", 32'h8001_7FFF, 32'h0000_7FFF);
        consume("lh_low");

        // 3: error paths, no memory access
        issue(32'h0000_3001, 3'd0);
        chk1("t3_mem_req", bus.mem_req, 1'b0);
        chk1("t3_valid", bus.res_valid, 1'b1);
        chk2("t3_err", bus.res_err, 2'd1);
        chk32("t3_data", bus.res_data, 32'h0);
        consume("t3");
        issue(32'h0000_3000, 3'd6);
        chk1("t3_type_mem_req", bus.mem_req, 1'b0);
        chk2("t3_type_err", bus.res_err, 2'd3);
        chk32("t3_type_data", bus.res_data, 32'h0);
        consume("t3_type");
        issue(32'h0000_3003, 3'd7);
        chk2("type_before_align", bus.res_err, 2'd3);
        consume("type_before_align");
        issue(32'h0000_3001, 3'd2);
        chk2("lhu_odd_err", bus.res_err, 2'd1);
        consume("lhu_odd");
        issue(32'h0000_3003, 3'd3);
        chk1("lb_odd_ok_req", bus.mem_req, 1'b1);
        ack_and_check("lb_odd_ok", 32'h7F00_0000, 32'h0000_007F);
        consume("lb_odd_ok");

        // 4: timeout with TIMEOUT=4
        issue(32'h0000_4000, 3'd0);
        n_req = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req) n_req++;
            if (bus.res_valid) begin
                done_seen = 1'b1;
                break;
            end
            step();
        end
        chk1("t4_done_seen", done_seen, 1'b1);
        chk32("t4_req_cycles", 32'(n_req), 32'd4);
        chk2("t4_err", bus.res_err, 2'd2);
        chk32("t4_data", bus.res_data, 32'h0);
        consume("t4");

        // ack in the 4th REQ cycle beats expiry
        issue(32'h0000_4000, 3'd0);
        step();
        step();
        step();
        chk1("t4b_req_still", bus.mem_req, 1'b1);
        ack_and_check("t4b", 32'h1234_5678, 32'h1234_5678);

        // 5: hold result with stray acks
        for (int i = 0; i < 5; i++) begin
            bus.mem_ack   = i[0];
            bus.mem_rdata = 32'hDEAD_0000 + 32'(i);
            step();
            chk32("t5_data_hold", bus.res_data, 32'h1234_5678);
            chk2("t5_err_hold", bus.res_err, 2'd0);
            chk1("t5_ld_ready", bus.ld_ready, 1'b0);
            chk1("t5_valid", bus.res_valid, 1'b1);
        end
        bus.mem_ack = 1'b0;
        consume("t5");

        // 6: reset mid-REQ
        issue(32'h0000_5000, 3'd0);
        chk1("t6_req_before", bus.mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t6_req_async", bus.mem_req, 1'b0);
        chk1("t6_ready_async", bus.ld_ready, 1'b1);
        chk32("t6_addr_clr", bus.mem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk1("t6_req_no_retry", bus.mem_req, 1'b0);
        issue(32'h0000_0000, 3'd4);
        ack_and_check("t6_lbu", 32'h0000_00AB, 32'h0000_00AB);
        consume("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
